// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MIPS MEM stage with byte-addressed load/store unit, multi-cycle
//            memory latency with stall handshake, and MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_ALU_res,
    input  logic [DATA_W-1:0] i_rt_reg,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic [DATA_W-1:0] i_pc_to_reg,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_write_pc,
    input  logic              is_stop_pipe,
    input  logic              is_MemRead,
    input  logic              is_MemWrite,
    input  logic [2:0]        is_load_store_type,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_output_mem,
    output logic [DATA_W-1:0] o_ALU_res,
    output logic [4:0]        o_addr_reg_dst,
    output logic [DATA_W-1:0] o_pc_to_reg,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_write_pc,
    output logic              os_stop_pipe,
    output logic              o_misalign,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Instruction latched at IDLE->ACCESS; upstream changes are ignored afterwards.
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_rt;
    logic [DATA_W-1:0]   r_pc;
    logic [4:0]          r_dst;
    logic [2:0]          r_type;
    logic                r_load;
    logic                r_regwrite;
    logic                r_memtoreg;
    logic                r_write_pc;
    logic                r_stop_pipe;

    logic [1:0]          w_lane;
    logic [ADDR_W-1:0]   w_widx;
    logic                w_is_b;
    logic                w_is_h;
    logic                w_unsigned;
    logic                w_misalign;
    logic [4:0]          w_shift;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_rd_shift;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_commit;
    logic                w_mem_we;

    assign w_lane     = r_alu[1:0];
    assign w_widx     = r_alu[ADDR_W+1:2];
    assign w_is_b     = (r_type == 3'b000) || (r_type == 3'b100);
    assign w_is_h     = (r_type == 3'b001) || (r_type == 3'b101);
    assign w_unsigned = r_type[2];
    assign w_misalign = (w_is_h & w_lane[0]) | (~w_is_b & ~w_is_h & (w_lane != 2'b00));
    assign w_commit   = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_mem_we   = w_commit & ~r_load & ~w_misalign;

    always_comb begin
        w_shift = 5'd0;
        w_mask  = '1;
        if (w_is_b) begin
            w_shift = {w_lane, 3'b000};
            w_mask  = DATA_W'(8'hFF) << w_shift;
        end else if (w_is_h) begin
            w_shift = {w_lane[1], 4'b0000};
            w_mask  = DATA_W'(16'hFFFF) << w_shift;
        end
    end

    assign w_wdata    = r_rt << w_shift;
    assign w_rd_word  = r_mem[w_widx];
    assign w_rd_shift = w_rd_word >> w_shift;

    always_comb begin
        w_load_data = w_rd_shift;
        if (w_is_b) begin
            w_load_data = w_unsigned ? DATA_W'(w_rd_shift[7:0])
                                     : {{(DATA_W-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
        end else if (w_is_h) begin
            w_load_data = w_unsigned ? DATA_W'(w_rd_shift[15:0])
                                     : {{(DATA_W-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
        end
    end

    assign o_dbg_data = r_mem[i_dbg_addr];

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_widx] <= (w_rd_word & ~w_mask) | (w_wdata & w_mask);
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_alu          <= '0;
            r_rt           <= '0;
            r_pc           <= '0;
            r_dst          <= '0;
            r_type         <= '0;
            r_load         <= 1'b0;
            r_regwrite     <= 1'b0;
            r_memtoreg     <= 1'b0;
            r_write_pc     <= 1'b0;
            r_stop_pipe    <= 1'b0;
            o_stall        <= 1'b0;
            o_valid        <= 1'b0;
            o_output_mem   <= '0;
            o_ALU_res      <= '0;
            o_addr_reg_dst <= '0;
            o_pc_to_reg    <= '0;
            os_RegWrite    <= 1'b0;
            os_MemtoReg    <= 1'b0;
            os_write_pc    <= 1'b0;
            os_stop_pipe   <= 1'b0;
            o_misalign     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && (is_MemRead || is_MemWrite)) begin
                        r_state     <= S_ACCESS;
                        r_cnt       <= c_CNT_INIT;
                        r_alu       <= i_ALU_res;
                        r_rt        <= i_rt_reg;
                        r_pc        <= i_pc_to_reg;
                        r_dst       <= i_addr_reg_dst;
                        r_type      <= is_load_store_type;
                        r_load      <= is_MemRead;
                        r_regwrite  <= is_RegWrite;
                        r_memtoreg  <= is_MemtoReg;
                        r_write_pc  <= is_write_pc;
                        r_stop_pipe <= is_stop_pipe;
                        o_stall     <= 1'b1;
                        o_valid     <= 1'b0;
                    end else begin
                        o_valid        <= i_valid;
                        o_output_mem   <= '0;
                        o_ALU_res      <= i_ALU_res;
                        o_addr_reg_dst <= i_addr_reg_dst;
                        o_pc_to_reg    <= i_pc_to_reg;
                        os_RegWrite    <= i_valid & is_RegWrite;
                        os_MemtoReg    <= i_valid & is_MemtoReg;
                        os_write_pc    <= i_valid & is_write_pc;
                        os_stop_pipe   <= i_valid & is_stop_pipe;
                        o_misalign     <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state        <= S_IDLE;
                        o_stall        <= 1'b0;
                        o_valid        <= 1'b1;
                        o_output_mem   <= (r_load && !w_misalign) ? w_load_data : '0;
                        o_ALU_res      <= r_alu;
                        o_addr_reg_dst <= r_dst;
                        o_pc_to_reg    <= r_pc;
                        os_RegWrite    <= r_regwrite & ~w_misalign;
                        os_MemtoReg    <= r_memtoreg;
                        os_write_pc    <= r_write_pc;
                        os_stop_pipe   <= r_stop_pipe;
                        o_misalign     <= w_misalign;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Directed self-checking bench for mem_stage_lsu (MEM_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_ALU_res;
    logic [31:0] i_rt_reg;
    logic [4:0]  i_addr_reg_dst;
    logic [31:0] i_pc_to_reg;
    logic        is_RegWrite, is_MemtoReg, is_write_pc, is_stop_pipe;
    logic        is_MemRead, is_MemWrite;
    logic [2:0]  is_load_store_type;
    logic [4:0]  i_dbg_addr;

    logic        o_stall, o_valid, o_misalign;
    logic [31:0] o_output_mem, o_ALU_res, o_pc_to_reg, o_dbg_data;
    logic [4:0]  o_addr_reg_dst;
    logic        os_RegWrite, os_MemtoReg, os_write_pc, os_stop_pipe;

    logic        o3_stall, o3_valid, o3_misalign;
    logic [31:0] o3_output_mem, o3_ALU_res, o3_pc_to_reg, o3_dbg_data;
    logic [4:0]  o3_addr_reg_dst;
    logic        os3_RegWrite, os3_MemtoReg, os3_write_pc, os3_stop_pipe;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .MEM_LAT(1)) u_dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_addr_reg_dst(i_addr_reg_dst),
        .i_pc_to_reg(i_pc_to_reg), .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
        .is_write_pc(is_write_pc), .is_stop_pipe(is_stop_pipe), .is_MemRead(is_MemRead),
        .is_MemWrite(is_MemWrite), .is_load_store_type(is_load_store_type),
        .o_stall(o_stall), .o_valid(o_valid), .o_output_mem(o_output_mem),
        .o_ALU_res(o_ALU_res), .o_addr_reg_dst(o_addr_reg_dst), .o_pc_to_reg(o_pc_to_reg),
        .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg), .os_write_pc(os_write_pc),
        .os_stop_pipe(os_stop_pipe), .o_misalign(o_misalign),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
    );

    mem_stage_lsu #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_addr_reg_dst(i_addr_reg_dst),
        .i_pc_to_reg(i_pc_to_reg), .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
        .is_write_pc(is_write_pc), .is_stop_pipe(is_stop_pipe), .is_MemRead(is_MemRead),
        .is_MemWrite(is_MemWrite), .is_load_store_type(is_load_store_type),
        .o_stall(o3_stall), .o_valid(o3_valid), .o_output_mem(o3_output_mem),
        .o_ALU_res(o3_ALU_res), .o_addr_reg_dst(o3_addr_reg_dst), .o_pc_to_reg(o3_pc_to_reg),
        .os_RegWrite(os3_RegWrite), .os_MemtoReg(os3_MemtoReg), .os_write_pc(os3_write_pc),
        .os_stop_pipe(os3_stop_pipe), .o_misalign(o3_misalign),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o3_dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one memory op for a single edge, then waits (bounded) for the stall to clear.
    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int stalls);
        i_valid = 1'b1; is_MemRead = rd; is_MemWrite = wr; is_load_store_type = typ;
        i_ALU_res = addr; i_rt_reg = data; is_RegWrite = rd;
        @(posedge clk); #1;
        i_valid = 1'b0; is_MemRead = 1'b0; is_MemWrite = 1'b0;
        stalls = 0;
        while (o_stall && stalls < 20) begin
            stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic dbg(input logic [4:0] idx, output logic [31:0] val);
        i_dbg_addr = idx;
        #1;
        val = o_dbg_data;
    endtask

    initial begin
        int          st;
        logic [31:0] v;

        i_reset_n = 1'b0; i_valid = 1'b0; i_ALU_res = '0; i_rt_reg = '0;
        i_addr_reg_dst = '0; i_pc_to_reg = '0; is_RegWrite = 1'b0; is_MemtoReg = 1'b0;
        is_write_pc = 1'b0; is_stop_pipe = 1'b0; is_MemRead = 1'b0; is_MemWrite = 1'b0;
        is_load_store_type = 3'b000; i_dbg_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_alu", o_ALU_res, 32'd0);
        check("rst_mem", o_output_mem, 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk); #1;

        mem_op(1'b0, 1'b1, 3'b011, 32'h08, 32'hDEADBEEF, st);
        check("sw_stall_cycles", st, 1);
        check("sw_valid", {31'd0, o_valid}, 32'd1);
        check("sw_misalign", {31'd0, o_misalign}, 32'd0);
        dbg(5'd2, v);
        check("sw_dbg2", v, 32'hDEADBEEF);
        mem_op(1'b1, 1'b0, 3'b011, 32'h08, 32'h0, st);
        check("lw_data", o_output_mem, 32'hDEADBEEF);
        check("lw_regwrite", {31'd0, os_RegWrite}, 32'd1);

        mem_op(1'b0, 1'b1, 3'b000, 32'h05, 32'h80, st);
        dbg(5'd1, v);
        check("sb_word1", v, 32'h00008000);
        mem_op(1'b1, 1'b0, 3'b000, 32'h05, 32'h0, st);
        check("lb_sext", o_output_mem, 32'hFFFFFF80);
        mem_op(1'b1, 1'b0, 3'b100, 32'h05, 32'h0, st);
        check("lbu_zext", o_output_mem, 32'h00000080);

        mem_op(1'b0, 1'b1, 3'b001, 32'h0E, 32'hAAAA1234, st);
        dbg(5'd3, v);
        check("sh_word3", v, 32'h12340000);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0E, 32'h0, st);
        check("lh_data", o_output_mem, 32'h00001234);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0D, 32'h0, st);
        check("lh_mis_flag", {31'd0, o_misalign}, 32'd1);
        check("lh_mis_regwr", {31'd0, os_RegWrite}, 32'd0);
        check("lh_mis_data", o_output_mem, 32'd0);
        check("lh_mis_stall", st, 1);
        mem_op(1'b0, 1'b1, 3'b011, 32'h0D, 32'hFFFFFFFF, st);
        dbg(5'd3, v);
        check("sw_mis_nowrite", v, 32'h12340000);

        mem_op(1'b0, 1'b1, 3'b001, 32'h0C, 32'h00008001, st);
        dbg(5'd3, v);
        check("sh_low_word3", v, 32'h12348001);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0C, 32'h0, st);
        check("lh_sext", o_output_mem, 32'hFFFF8001);
        mem_op(1'b1, 1'b0, 3'b101, 32'h0C, 32'h0, st);
        check("lhu_zext", o_output_mem, 32'h00008001);

        i_valid = 1'b1; i_ALU_res = 32'h7; i_pc_to_reg = 32'h100; is_RegWrite = 1'b1;
        i_addr_reg_dst = 5'd9;
        #1;
        check("add_nostall_pre", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
        check("add_alu", o_ALU_res, 32'h7);
        check("add_valid", {31'd0, o_valid}, 32'd1);
        check("add_stall", {31'd0, o_stall}, 32'd0);
        check("add_pc", o_pc_to_reg, 32'h100);
        check("add_dst", {27'd0, o_addr_reg_dst}, 32'd9);
        check("add_regwr", {31'd0, os_RegWrite}, 32'd1);
        i_valid = 1'b0;
        @(posedge clk); #1;
        check("bubble_valid", {31'd0, o_valid}, 32'd0);
        check("bubble_regwr", {31'd0, os_RegWrite}, 32'd0);

        mem_op(1'b0, 1'b1, 3'b011, 32'h80, 32'hA5A5A5A5, st);
        dbg(5'd0, v);
        check("sw_wrap_word0", v, 32'hA5A5A5A5);

        i_valid = 1'b1; is_MemWrite = 1'b1; is_MemRead = 1'b0; is_load_store_type = 3'b011;
        i_ALU_res = 32'h10; i_rt_reg = 32'h55;
        @(posedge clk); #1;
        check("abort_stall_high", {31'd0, o_stall}, 32'd1);
        i_valid = 1'b0; is_MemWrite = 1'b0;
        i_reset_n = 1'b0;
        #1;
        check("abort_stall", {31'd0, o_stall}, 32'd0);
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_alu", o_ALU_res, 32'd0);
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dbg(5'd4, v);
        check("abort_word4", v, 32'd0);
        dbg(5'd2, v);
        check("rst_clear_word2", v, 32'd0);

        i_valid = 1'b1; is_MemRead = 1'b1; is_load_store_type = 3'b011; i_ALU_res = 32'h08;
        @(posedge clk); #1;
        i_ALU_res = 32'h44;
        check("lat3_valid_during", {31'd0, o3_valid}, 32'd0);
        st = 0;
        while (o3_stall && st < 20) begin
            st++;
            @(posedge clk); #1;
        end
        check("lat3_stall_cycles", st, 3);
        check("lat3_valid", {31'd0, o3_valid}, 32'd1);
        check("lat3_alu_latched", o3_ALU_res, 32'h08);
        check("lat3_data", o3_output_mem, 32'd0);
        i_valid = 1'b0; is_MemRead = 1'b0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
